// File: rtl/kugelblitz_byte_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kugelblitz_byte_capture_pkg
//  Description : Shared register map, CTRL/STATUS bit positions and FSM
//                encodings for the kugelblitz byte capture tap.
//  Revision    : 1.0 - initial release
// ============================================================================
package kugelblitz_byte_capture_pkg;

  // Register word index, decoded from addr[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_OFFSET   = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_DATA     = 3'd3;
  localparam logic [2:0] REG_FRAMES   = 3'd4;
  localparam logic [2:0] REG_CAPTURES = 3'd5;
  localparam logic [2:0] REG_MISSES   = 3'd6;

  // CTRL / STATUS / DATA bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int STATUS_OVF_BIT  = 16;
  localparam int DATA_VALID_BIT  = 31;

  // AXI-Lite write channel states
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;

  // AXI-Lite read channel states
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Word returned by a DATA read: valid flag plus the popped byte
  function automatic logic [31:0] data_word(input logic valid, input logic [7:0] byte_val);
    logic [31:0] w;
    w = '0;
    if (valid) begin
      w[DATA_VALID_BIT] = 1'b1;
      w[7:0]            = byte_val;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kugelblitz_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kugelblitz_capture_fifo
//  Description : Synchronous byte FIFO with flush. A push into a full FIFO
//                is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module kugelblitz_capture_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and level bookkeeping; flush overrides any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kugelblitz_byte_capture.sv
`default_nettype none
// ============================================================================
//  Module      : kugelblitz_byte_capture
//  Description : Passive AXI-Stream tap that samples one byte per frame at a
//                programmed offset and queues it for AXI-Lite readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module kugelblitz_byte_capture
  import kugelblitz_byte_capture_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH/8,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready
);

  generate
    if (DATA_WIDTH != 512 || KEEP_WIDTH != 64) begin : g_bad_stream_width
      $error("kugelblitz_byte_capture: only a 512-bit stream is supported");
    end
    if (AXIL_DATA_WIDTH != 32 || AXIL_STRB_WIDTH != 4) begin : g_bad_axil_width
      $error("kugelblitz_byte_capture: only 32-bit AXI-Lite data is supported");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_depth
      $error("kugelblitz_byte_capture: FIFO_DEPTH must be a power of two in 2..256");
    end
  endgenerate

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Software-visible state
  logic        ctrl_en_q;
  logic [11:0] offset_q;
  logic        overflow_q;
  logic [31:0] frames_q, captures_q, misses_q;
  // AXI-Lite channel state
  logic [0:0]  w_state_q, w_state_d;
  logic [0:0]  r_state_q, r_state_d;
  logic [31:0] rdata_q;
  logic [31:0] rd_word;
  logic [31:0] status_word;
  // Stream tracking
  logic [5:0]  beat_cnt_q;
  logic        captured_q;
  logic        shadow_en_q;
  logic [11:0] shadow_off_q;
  logic        push_q;
  logic [7:0]  push_byte_q;
  // FIFO interface
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full, fifo_empty, fifo_pop;

  logic       aw_hs, ar_hs, clear;
  logic       first_beat, en_eff, capture, miss, push_ok;
  logic [11:0] off_eff;
  logic [2:0] wr_idx, rd_idx;

  assign wr_idx = s_axil_awaddr[4:2];
  assign rd_idx = s_axil_araddr[4:2];

  // Ready is combinational on valid so each handshake takes a single cycle
  assign aw_hs          = rst_n && (w_state_q == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
  assign ar_hs          = rst_n && (r_state_q == R_IDLE) && s_axil_arvalid;
  assign s_axil_awready = aw_hs;
  assign s_axil_wready  = aw_hs;
  assign s_axil_arready = ar_hs;
  assign s_axil_bvalid  = (w_state_q == W_RESP);
  assign s_axil_rvalid  = (r_state_q == R_DATA);
  assign s_axil_bresp   = 2'b00;
  assign s_axil_rresp   = 2'b00;
  assign s_axil_rdata   = rdata_q;

  assign clear    = aw_hs && (wr_idx == REG_CTRL) && s_axil_wstrb[0] && s_axil_wdata[CTRL_CLEAR_BIT];
  assign fifo_pop = ar_hs && (rd_idx == REG_DATA) && !fifo_empty;
  assign push_ok  = push_q && (!fifo_full || fifo_pop);

  // On beat 0 the live registers apply; later beats use the frame's shadow copy
  assign first_beat = (beat_cnt_q == 6'd0);
  assign en_eff     = first_beat ? ctrl_en_q : shadow_en_q;
  assign off_eff    = first_beat ? offset_q  : shadow_off_q;
  assign capture    = s_axis_tvalid && en_eff && !captured_q &&
                      (beat_cnt_q == off_eff[11:6]) && s_axis_tkeep[off_eff[5:0]];
  assign miss       = s_axis_tvalid && s_axis_tlast && en_eff && !captured_q && !capture;

  // Write channel state: IDLE until a combined AW/W handshake, RESP until bready
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)         w_state_d = W_RESP;
      W_RESP:  if (s_axil_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel state: IDLE until AR handshake, DATA until rready
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)         r_state_d = R_DATA;
      R_DATA:  if (s_axil_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Status word assembly
  always_comb begin
    status_word                 = '0;
    status_word[8:0]            = 9'(fifo_level);
    status_word[STATUS_OVF_BIT] = overflow_q;
  end

  // Read data mux; unmapped words read as zero
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_CTRL:     rd_word = {31'd0, ctrl_en_q};
      REG_OFFSET:   rd_word = {20'd0, offset_q};
      REG_STATUS:   rd_word = status_word;
      REG_DATA:     rd_word = data_word(!fifo_empty, fifo_head);
      REG_FRAMES:   rd_word = frames_q;
      REG_CAPTURES: rd_word = captures_q;
      REG_MISSES:   rd_word = misses_q;
      default:      rd_word = '0;
    endcase
  end

  // AXI-Lite channel registers and programmable CTRL/OFFSET fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      ctrl_en_q <= 1'b0;
      offset_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      if (ar_hs) rdata_q <= rd_word;
      if (aw_hs) begin
        if (wr_idx == REG_CTRL && s_axil_wstrb[0]) ctrl_en_q <= s_axil_wdata[CTRL_ENABLE_BIT];
        if (wr_idx == REG_OFFSET) begin
          if (s_axil_wstrb[0]) offset_q[7:0]  <= s_axil_wdata[7:0];
          if (s_axil_wstrb[1]) offset_q[11:8] <= s_axil_wdata[11:8];
        end
      end
    end
  end

  // Beat tracking, per-frame shadow latch and the one-cycle capture pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      captured_q   <= 1'b0;
      shadow_en_q  <= 1'b0;
      shadow_off_q <= '0;
      push_q       <= 1'b0;
      push_byte_q  <= '0;
    end else begin
      push_q <= capture;
      if (capture) push_byte_q <= s_axis_tdata[{off_eff[5:0], 3'b000} +: 8];
      if (s_axis_tvalid) begin
        if (first_beat) begin
          shadow_en_q  <= ctrl_en_q;
          shadow_off_q <= offset_q;
        end
        if (s_axis_tlast) begin
          beat_cnt_q <= '0;
          captured_q <= 1'b0;
        end else begin
          if (beat_cnt_q != 6'd63) beat_cnt_q <= beat_cnt_q + 6'd1;
          if (capture) captured_q <= 1'b1;
        end
      end
    end
  end

  // Statistics counters and sticky overflow; CLEAR takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q   <= '0;
      captures_q <= '0;
      misses_q   <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      frames_q   <= '0;
      captures_q <= '0;
      misses_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tlast) frames_q <= frames_q + 32'd1;
      if (miss)                          misses_q <= misses_q + 32'd1;
      if (push_ok)                       captures_q <= captures_q + 32'd1;
      if (push_q && !push_ok)            overflow_q <= 1'b1;
    end
  end

  kugelblitz_capture_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_q),
    .push_data_i (push_byte_q),
    .pop_i       (fifo_pop),
    .flush_i     (clear),
    .head_o      (fifo_head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  logic unused_bits;
  assign unused_bits = ^{s_axil_awaddr[AXIL_ADDR_WIDTH-1:5], s_axil_awaddr[1:0],
                         s_axil_araddr[AXIL_ADDR_WIDTH-1:5], s_axil_araddr[1:0],
                         s_axil_wdata[AXIL_DATA_WIDTH-1:12], s_axil_wstrb[AXIL_STRB_WIDTH-1:2]};

endmodule
`default_nettype wire

// File: tb/tb_kugelblitz_byte_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kugelblitz_byte_capture
//  Description : Self-checking bench for kugelblitz_byte_capture with a
//                frame-level reference model (byte queue plus counters).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kugelblitz_byte_capture;

  localparam logic [31:0] A_CTRL = 32'h00, A_OFFSET = 32'h04, A_STATUS = 32'h08, A_DATA = 32'h0C;
  localparam logic [31:0] A_FRAMES = 32'h10, A_CAPTURES = 32'h14, A_MISSES = 32'h18;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic         s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
  logic [31:0]  s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0;
  logic [3:0]   s_axil_wstrb = '0;
  logic         s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0;
  logic         s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
  logic         s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]   s_axil_bresp, s_axil_rresp;
  logic [31:0]  s_axil_rdata;

  always #5 clk = ~clk;

  kugelblitz_byte_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what software should observe, frame by frame
  logic [7:0]   exp_q[$];
  int unsigned  m_frames = 0, m_captures = 0, m_misses = 0;
  bit           m_ovf = 1'b0, m_en = 1'b0;
  int           m_off = 0;
  logic [511:0] fr_data[$];
  logic [63:0]  fr_keep[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (exp_q.size() == DEPTH) m_ovf = 1'b1;
    else begin
      exp_q.push_back(b);
      m_captures++;
    end
  endfunction

  // One frame as software sees it: capture if the offset lands on a kept byte
  function automatic void model_frame(input bit en, input int off);
    int b, l;
    logic [511:0] d;
    logic [63:0]  k;
    b = off / 64;
    l = off % 64;
    m_frames++;
    if (en) begin
      if (b < fr_data.size()) begin
        d = fr_data[b];
        k = fr_keep[b];
        if (k[l]) model_push(d[l*8 +: 8]);
        else m_misses++;
      end else m_misses++;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_frames = 0; m_captures = 0; m_misses = 0; m_ovf = 1'b0;
  endfunction

  function automatic void make_frame(input int nbeats);
    logic [511:0] d;
    fr_data.delete();
    fr_keep.delete();
    for (int i = 0; i < nbeats; i++) begin
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      fr_data.push_back(d);
      fr_keep.push_back({64{1'b1}});
    end
  endfunction

  task automatic send_beat(input int idx, input bit last);
    @(negedge clk);
    s_axis_tdata  = fr_data[idx];
    s_axis_tkeep  = fr_keep[idx];
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < fr_data.size(); i++) send_beat(i, i == fr_data.size() - 1);
    model_frame(m_en, m_off);
    @(negedge clk);
  endtask

  task automatic run_frame(input int nbeats);
    make_frame(nbeats);
    send_frame();
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data);
    int t;
    @(negedge clk);
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    t = 0;
    #1;
    while (!(s_axil_awready && s_axil_wready) && t <= 50) begin
      @(negedge clk); #1; t++;
    end
    if (t > 50) timeout_fail("aw_handshake");
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    check("bvalid_held", {31'd0, s_axil_bvalid}, 32'd1);
    s_axil_bready = 1'b1;
    @(negedge clk);
    s_axil_bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data);
    int t;
    @(negedge clk);
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    t = 0;
    #1;
    while (!s_axil_arready && t <= 50) begin
      @(negedge clk); #1; t++;
    end
    if (t > 50) timeout_fail("ar_handshake");
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    check("rvalid_held", {31'd0, s_axil_rvalid}, 32'd1);
    data = s_axil_rdata;
    s_axil_rready = 1'b1;
    @(negedge clk);
    s_axil_rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic read_data_check(input string tag);
    logic [31:0] exp;
    exp = 32'd0;
    if (exp_q.size() != 0) exp = {24'h800000, exp_q.pop_front()};
    read_check(tag, A_DATA, exp);
  endtask

  task automatic check_status(input string tag);
    read_check(tag, A_STATUS, {15'd0, m_ovf, 7'd0, 9'(exp_q.size())});
  endtask

  task automatic check_counters(input string tag);
    read_check({tag, "_frames"},   A_FRAMES,   m_frames);
    read_check({tag, "_captures"}, A_CAPTURES, m_captures);
    read_check({tag, "_misses"},   A_MISSES,   m_misses);
  endtask

  task automatic set_offset(input int off);
    m_off = off;
    axil_write(A_OFFSET, off);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  popped;
    int t;

    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, s_axil_awready}, 32'd0);
    check("rst_bvalid",  {31'd0, s_axil_bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, s_axil_rvalid},  32'd0);
    check("rst_rdata",   s_axil_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_status("rst_status");
    check_counters("rst");
    read_data_check("rst_data_empty");

    // ---- OFFSET=70, three 2-beat frames with known bytes at beat1 lane6
    set_offset(70);
    m_en = 1'b1;
    axil_write(A_CTRL, 32'h1);
    read_check("ctrl_readback", A_CTRL, 32'h1);
    read_check("offset_readback", A_OFFSET, 32'd70);
    begin
      logic [7:0] pat [3];
      pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h3C;
      for (int f = 0; f < 3; f++) begin
        make_frame(2);
        fr_data[1][6*8 +: 8] = pat[f];
        send_frame();
      end
    end
    for (int i = 0; i < 4; i++) read_data_check("data_basic");
    check_counters("basic");

    // ---- misses: offset past frame end, then keep bit clear
    set_offset(200);
    run_frame(2);
    set_offset(6);
    make_frame(1);
    fr_keep[0][6] = 1'b0;
    send_frame();
    check_counters("miss");
    check_status("miss_status");

    // ---- overflow: 20 frames, no reads
    axil_write(A_CTRL, 32'h3);
    model_clear();
    read_check("clear_ctrl_reads_en", A_CTRL, 32'h1);
    set_offset($urandom_range(0, 127));
    for (int f = 0; f < 20; f++) run_frame(2);
    check_status("ovf_status");
    check_counters("ovf");
    read_data_check("ovf_first_pop");
    axil_write(A_CTRL, 32'h3);
    model_clear();
    check_status("clear_status");
    check_counters("clear");

    // ---- full FIFO, push coincides with DATA pop
    set_offset($urandom_range(0, 63));
    for (int f = 0; f < DEPTH; f++) run_frame(1);
    check_status("full_status");
    make_frame(1);
    @(negedge clk);
    s_axis_tdata = fr_data[0]; s_axis_tkeep = fr_keep[0];
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axil_araddr = A_DATA; s_axil_arvalid = 1'b1;
    #1;
    check("coinc_arready", {31'd0, s_axil_arready}, 32'd1);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    popped = exp_q.pop_front();
    model_frame(m_en, m_off);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    check("coinc_data", s_axil_rdata, {24'h800000, popped});
    s_axil_rready = 1'b1;
    @(negedge clk);
    s_axil_rready = 1'b0;
    check_status("coinc_status");
    check_counters("coinc");

    // ---- drain under random back-pressure
    for (int i = 0; i < DEPTH + 1; i++) read_data_check("drain");
    check_status("drain_status");

    // ---- OFFSET rewritten mid-frame applies from the next frame
    set_offset(0);
    make_frame(2);
    send_beat(0, 1'b0);
    axil_write(A_OFFSET, 32'd64);
    send_beat(1, 1'b1);
    model_frame(m_en, 0);
    m_off = 64;
    run_frame(2);
    read_data_check("midframe_first");
    read_data_check("midframe_second");

    // ---- reset mid-frame with outstanding write response and read data
    run_frame(1);
    make_frame(2);
    send_beat(0, 1'b0);
    @(negedge clk);
    s_axil_araddr = A_STATUS; s_axil_arvalid = 1'b1;
    s_axil_awaddr = A_OFFSET; s_axil_wdata = 32'd9; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    t = 0;
    while (!(s_axil_bvalid && s_axil_rvalid) && t < 20) begin
      @(negedge clk);
      if (s_axil_rvalid) s_axil_arvalid = 1'b0;
      if (s_axil_bvalid) begin s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; end
      t++;
    end
    s_axil_arvalid = 1'b0; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    if (t >= 20) timeout_fail("prereset_outstanding");
    rst_n = 1'b0;
    #1;
    check("rstmid_bvalid", {31'd0, s_axil_bvalid}, 32'd0);
    check("rstmid_rvalid", {31'd0, s_axil_rvalid}, 32'd0);
    model_clear();
    m_en = 1'b0; m_off = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_status("rstmid_status");
    set_offset(3);
    m_en = 1'b1;
    axil_write(A_CTRL, 32'h1);
    run_frame(1);
    read_data_check("rstmid_frame_start");
    check_counters("rstmid");

    // ---- random frames with random offsets and lengths
    for (int f = 0; f < 10; f++) begin
      set_offset($urandom_range(0, 191));
      make_frame($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) fr_keep[m_off / 64 < fr_data.size() ? m_off / 64 : 0][m_off % 64] = 1'b0;
      send_frame();
      if ($urandom_range(0, 1) == 1) read_data_check("rand_data");
    end
    check_status("rand_status");
    check_counters("rand");
    while (exp_q.size() != 0) read_data_check("rand_drain");
    read_data_check("rand_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so a stuck handshake cannot hang the run
  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
